// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM encoding, frame field widths,
// the default sync marker and the word-to-byte-address helper.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_SYNC = 3'd0,
    ST_LEN_LO    = 3'd1,
    ST_LEN_HI    = 3'd2,
    ST_DATA      = 3'd3,
    ST_CSUM      = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERROR     = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 16;

  // Instruction memory is byte addressed; each word occupies four bytes.
  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/imem_boot_loader_word_packer.sv
// Packs incoming bytes MSB first into 32-bit words. word_done flags the
// cycle the 4th byte is taken; word/word_valid present the finished word on
// the following cycle. clear drops any partially collected word.
module imem_boot_loader_word_packer
  import imem_boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic              byte_valid,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              word_done
);

  logic [1:0]               byte_cnt;
  logic [WORD_W-BYTE_W-1:0] shift;

  assign word_done = byte_valid && (byte_cnt == 2'd3);

  // Byte shift-in, byte counter and one-cycle word pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt   <= 2'd0;
      shift      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      byte_cnt   <= 2'd0;
      shift      <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_done;
      if (byte_valid) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (word_done) begin
          word <= {shift, byte_data};
        end else begin
          shift <= {shift[WORD_W-2*BYTE_W-1:0], byte_data};
        end
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a framed program image over a valid/ready byte stream, writes it
// into instruction memory one word at a time and keeps the core in reset
// until the whole image has arrived with a matching checksum.
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both 1; in_ready depends only on state (0 in DONE and ERROR).
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int         IMEM_WORDS     = 256,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        start,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        cpu_enable,
  output logic        done,
  output logic        error,
  output logic [2:0]  dbg_state
);

  localparam int IDX_W = $clog2(IMEM_WORDS) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(IMEM_WORDS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t             state, state_next;
  logic               accept, in_frame, timeout_hit, restart;
  logic               pack_valid, pack_clear, word_done, last_word;
  logic [LEN_W-1:0]   len, hdr_len;
  logic [IDX_W-1:0]   word_idx;
  logic [7:0]         csum;
  logic [TMO_W-1:0]   tcnt;

  assign in_ready    = (state != ST_DONE) && (state != ST_ERROR);
  assign accept      = in_valid && in_ready;
  assign in_frame    = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                       (state == ST_DATA)   || (state == ST_CSUM);
  // A byte arriving on the expiry cycle keeps the frame alive.
  assign timeout_hit = in_frame && !accept && (tcnt == TMO_LAST);
  assign restart     = start && !in_ready;
  assign hdr_len     = {in_data, len[7:0]};
  assign last_word   = (LEN_W'(word_idx) + LEN_W'(1)) == len;
  assign pack_valid  = accept && (state == ST_DATA);
  assign pack_clear  = (state != ST_DATA);
  assign dbg_state   = state;

  imem_boot_loader_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .byte_data  (in_data),
    .byte_valid (pack_valid),
    .word       (imem_wdata),
    .word_valid (imem_we),
    .word_done  (word_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_WAIT_SYNC;
    else       state <= state_next;
  end

  // Frame sequencing: next state from the accepted byte, start and timeout.
  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT_SYNC: if (accept && (in_data == SYNC_BYTE)) state_next = ST_LEN_LO;
      ST_LEN_LO:    if (accept) state_next = ST_LEN_HI;
      ST_LEN_HI: begin
        if (accept) begin
          if (hdr_len == '0)          state_next = ST_CSUM;
          else if (hdr_len > MAX_LEN) state_next = ST_ERROR;
          else                        state_next = ST_DATA;
        end
      end
      ST_DATA:      if (word_done && last_word) state_next = ST_CSUM;
      ST_CSUM:      if (accept) state_next = (in_data == csum) ? ST_DONE : ST_ERROR;
      ST_DONE,
      ST_ERROR:     if (restart) state_next = ST_WAIT_SYNC;
      default:      state_next = ST_WAIT_SYNC;
    endcase
    if (timeout_hit) state_next = ST_ERROR;
  end

  // Length capture, word index, checksum and write address.
  always_ff @(posedge clk) begin
    if (reset) begin
      len       <= '0;
      word_idx  <= '0;
      csum      <= '0;
      imem_addr <= '0;
    end else if (restart || (state == ST_WAIT_SYNC)) begin
      len      <= '0;
      word_idx <= '0;
      csum     <= '0;
    end else if (accept) begin
      case (state)
        ST_LEN_LO: len[7:0]  <= in_data;
        ST_LEN_HI: len[15:8] <= in_data;
        ST_DATA: begin
          csum <= csum ^ in_data;
          if (word_done) begin
            imem_addr <= word_addr(32'(word_idx));
            word_idx  <= word_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Inter-byte idle counter, only running while inside a frame.
  always_ff @(posedge clk) begin
    if (reset || !in_frame || accept) tcnt <= '0;
    else                              tcnt <= tcnt + 1'b1;
  end

  // Registered core control and status, following the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_reset  <= 1'b1;
      cpu_enable <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      cpu_reset  <= (state_next != ST_DONE);
      cpu_enable <= (state_next == ST_DONE);
      done       <= (state_next == ST_DONE);
      error      <= (state_next == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table of directed frames, hand-written
// corner sequences and randomized frames checked against a frame parser.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        start = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        cpu_enable;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state;

  imem_boot_loader #(
    .IMEM_WORDS     (256),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .cpu_enable (cpu_enable),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  frame_q[$];
  logic [7:0]  garb_q[$];
  logic [31:0] words_q[$];
  bit          exp_done, exp_err;

  typedef struct {
    int          garbage;
    int          nwords;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          bad_csum;
    bit          exp_done;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] garb_tab[3];

  // write monitor: every imem_we cycle is one {addr, data} record
  always @(negedge clk) begin
    if (imem_we === 1'b1) got_q.push_back({imem_addr, imem_wdata});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // drives one byte and returns on the negedge after it was accepted
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: got in_ready=%0b expected 1 within 50 cycles", in_ready);
    end else begin
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send_byte(frame_q[i]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic restart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_q.delete();
  endtask

  // frame = garbage, sync, length, words MSB first, xor checksum
  task automatic build_frame(input bit bad);
    logic [15:0] n;
    logic [7:0]  cs;
    frame_q.delete();
    foreach (garb_q[g]) frame_q.push_back(garb_q[g]);
    n = 16'(words_q.size());
    frame_q.push_back(8'hA5);
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    cs = 8'h00;
    foreach (words_q[k]) begin
      for (int j = 0; j < 4; j++) begin
        frame_q.push_back(words_q[k][31-8*j -: 8]);
        cs = cs ^ words_q[k][31-8*j -: 8];
      end
    end
    frame_q.push_back(bad ? (cs ^ 8'h01) : cs);
  endtask

  // reference: parse the byte stream the way the frame format defines it
  task automatic model_frame();
    int          i;
    logic [15:0] n;
    logic [7:0]  cs;
    logic [31:0] w;
    exp_q.delete();
    exp_done = 0;
    exp_err = 0;
    i = 0;
    while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
    if (i + 2 >= frame_q.size()) return;
    n = {frame_q[i+2], frame_q[i+1]};
    i += 3;
    if (n > 16'd256) begin
      exp_err = 1;
      return;
    end
    cs = 8'h00;
    for (int k = 0; k < int'(n); k++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) begin
        w[31-8*j -: 8] = frame_q[i];
        cs = cs ^ frame_q[i];
        i++;
      end
      exp_q.push_back({32'(k * 4), w});
    end
    if (frame_q[i] == cs) exp_done = 1;
    else                  exp_err = 1;
  endtask

  task automatic compare_writes(input string name);
    chk({name, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({name, "_write"}, (i < got_q.size()) ? got_q[i] : 64'hx, exp_q[i]);
    end
  endtask

  initial begin
    garb_tab = '{8'h00, 8'hFF, 8'h13};
    vecs[0] = '{garbage:0, nwords:2, w0:32'h20010005, w1:32'h8C020000,
                bad_csum:0, exp_done:1, exp_err:0, exp_writes:2};
    vecs[1] = '{garbage:3, nwords:1, w0:32'h12345678, w1:32'h0,
                bad_csum:0, exp_done:1, exp_err:0, exp_writes:1};
    vecs[2] = '{garbage:0, nwords:2, w0:32'h20010005, w1:32'h8C020000,
                bad_csum:1, exp_done:0, exp_err:1, exp_writes:2};
    vecs[3] = '{garbage:0, nwords:0, w0:32'h0, w1:32'h0,
                bad_csum:0, exp_done:1, exp_err:0, exp_writes:0};

    // reset values
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_cpu_enable", cpu_enable, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);

    // directed table
    for (int v = 0; v < 4; v++) begin
      restart();
      garb_q.delete();
      words_q.delete();
      for (int g = 0; g < vecs[v].garbage; g++) garb_q.push_back(garb_tab[g]);
      if (vecs[v].nwords > 0) words_q.push_back(vecs[v].w0);
      if (vecs[v].nwords > 1) words_q.push_back(vecs[v].w1);
      build_frame(vecs[v].bad_csum);
      model_frame();
      send_frame(0);
      chk("vec_done_entry", done, vecs[v].exp_done);
      idle(3);
      compare_writes("vec");
      chk("vec_table_nwrites", 64'(got_q.size()), 64'(vecs[v].exp_writes));
      chk("vec_done", done, vecs[v].exp_done);
      chk("vec_error", error, vecs[v].exp_err);
      chk("vec_cpu_enable", cpu_enable, vecs[v].exp_done);
      chk("vec_cpu_reset", cpu_reset, !vecs[v].exp_done);
      chk("vec_in_ready", in_ready, 0);
    end

    // length above memory depth: error right after LEN_HI
    restart();
    frame_q = '{8'hA5, 8'h01, 8'h01};
    model_frame();
    send_frame(0);
    chk("len_err_error", error, exp_err);
    chk("len_err_in_ready", in_ready, 0);
    idle(3);
    compare_writes("len_err");
    chk("len_err_cpu_enable", cpu_enable, 0);

    // timeout: 15 idle cycles survive (start ignored mid-frame), 16th expires
    restart();
    chk("restart_error", error, 0);
    chk("restart_cpu_reset", cpu_reset, 1);
    chk("restart_in_ready", in_ready, 1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(14);
    chk("tmo_15_no_error", error, 0);
    idle(1);
    chk("tmo_16_error", error, 1);
    chk("tmo_cpu_enable", cpu_enable, 0);
    chk("tmo_cpu_reset", cpu_reset, 1);
    idle(2);
    chk("tmo_no_write", 64'(got_q.size()), 0);
    restart();
    chk("tmo_restart_error", error, 0);
    chk("tmo_restart_in_ready", in_ready, 1);

    // byte on the expiry cycle wins and restarts the idle count
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
    idle(15);
    send_byte(8'h22);
    idle(15);
    chk("tmo_win_no_error", error, 0);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h44);
    chk("tmo_win_done", done, 1);
    idle(2);
    frame_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    model_frame();
    compare_writes("tmo_win");

    // randomized frames with random in_valid gaps below the timeout
    for (int r = 0; r < 8; r++) begin
      restart();
      garb_q.delete();
      words_q.delete();
      if (r == 0) begin
        words_q.push_back(32'h20010005);
        words_q.push_back(32'h8C020000);
      end else begin
        repeat ($urandom_range(0, 2)) garb_q.push_back(8'($urandom_range(0, 8'hA4)));
        repeat ($urandom_range(1, 3)) words_q.push_back($urandom);
      end
      build_frame((r != 0) && ($urandom_range(0, 3) == 0));
      model_frame();
      send_frame(10);
      idle(3);
      compare_writes("rand");
      chk("rand_done", done, exp_done);
      chk("rand_error", error, exp_err);
      chk("rand_cpu_enable", cpu_enable, exp_done);
    end

    // reset in the middle of a word: nothing partial is ever written
    restart();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_cpu_reset", cpu_reset, 1);
    chk("midrst_done", done, 0);
    chk("midrst_in_ready", in_ready, 1);
    send_byte(8'h33); send_byte(8'h44);
    idle(3);
    chk("midrst_no_write", 64'(got_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
